// File: rtl/bet_controller_pkg.sv
// bet_controller_pkg: shared state enum, bet side codes and parameter defaults.
package bet_controller_pkg;
    typedef enum logic [1:0] {BET, PLAY, SETTLE, BROKE} state_t;
    localparam logic [1:0] SIDE_NONE   = 2'b00;
    localparam logic [1:0] SIDE_PLAYER = 2'b01;
    localparam logic [1:0] SIDE_DEALER = 2'b10;
    localparam logic [1:0] SIDE_TIE    = 2'b11;
    localparam logic [7:0] DEFAULT_INIT_BALANCE = 8'd50;
    localparam int DEFAULT_TIE_MULT = 8;
endpackage

// File: rtl/bet_controller_if.sv
// bet_controller_if: bet requests, round results and balance status between game logic and the bet controller.
interface bet_controller_if;
    logic [7:0] bet_amount;
    logic [1:0] bet_side;
    logic       bet_valid;
    logic       round_done;
    logic       player_win;
    logic       dealer_win;
    logic       betenabled;
    logic       updatebalanceenable;
    logic [7:0] balance;
    logic       bet_error;
    logic       broke;
    modport master (
        output bet_amount, bet_side, bet_valid, round_done, player_win, dealer_win,
        input  betenabled, updatebalanceenable, balance, bet_error, broke
    );
    modport slave (
        input  bet_amount, bet_side, bet_valid, round_done, player_win, dealer_win,
        output betenabled, updatebalanceenable, balance, bet_error, broke
    );
endinterface

// File: rtl/payout_calc.sv
// payout_calc: combinational settlement of one bet into a saturated next balance.
module payout_calc
    import bet_controller_pkg::*;
#(
    parameter int TIE_MULT = DEFAULT_TIE_MULT
) (
    input  logic [7:0] balance,
    input  logic [7:0] amount,
    input  logic [1:0] side,
    input  logic       player_win,
    input  logic       dealer_win,
    output logic [7:0] next_balance
);
    logic        tie;
    logic        win;
    logic        push;
    logic [11:0] gain;
    logic [11:0] sum;
    // 12-bit sum so a full-scale tie payout cannot wrap before saturation
    always_comb begin
        tie  = player_win & dealer_win;
        win  = (side == SIDE_PLAYER && player_win && !dealer_win) ||
               (side == SIDE_DEALER && dealer_win && !player_win) ||
               (side == SIDE_TIE && tie);
        push = tie && (side == SIDE_PLAYER || side == SIDE_DEALER);
        gain = side == SIDE_TIE ? 12'(TIE_MULT) * {4'd0, amount} : {4'd0, amount};
        sum  = {4'd0, balance} + gain;
        next_balance = push ? balance
                     : win  ? (sum > 12'd255 ? 8'd255 : sum[7:0])
                     : balance - amount;
    end
endmodule

// File: rtl/bet_controller.sv
// bet_controller: accepts bets, waits for the hand result, settles the balance and
// parks in BROKE once the balance reaches zero.
module bet_controller
    import bet_controller_pkg::*;
#(
    parameter logic [7:0] INIT_BALANCE = DEFAULT_INIT_BALANCE,
    parameter int         TIE_MULT     = DEFAULT_TIE_MULT
) (
    input logic       slow_clock,
    input logic       reset,
    bet_controller_if.slave bus
);
    state_t     state;
    logic [7:0] bal;
    logic [7:0] amount;
    logic [1:0] side;
    logic       pw;
    logic       dw;
    logic       en;
    logic       upd;
    logic       err;
    logic       brk;
    logic [7:0] new_balance;
    logic       accept;

    assign accept = bus.bet_side != SIDE_NONE && bus.bet_amount != 8'd0 && bus.bet_amount <= bal;
    assign bus.betenabled          = en;
    assign bus.updatebalanceenable = upd;
    assign bus.balance             = bal;
    assign bus.bet_error           = err;
    assign bus.broke               = brk;

    payout_calc #(.TIE_MULT(TIE_MULT)) u_payout (
        .balance(bal),
        .amount(amount),
        .side(side),
        .player_win(pw),
        .dealer_win(dw),
        .next_balance(new_balance)
    );

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            state  <= BET;
            bal    <= INIT_BALANCE;
            amount <= 8'd0;
            side   <= SIDE_NONE;
            pw     <= 1'b0;
            dw     <= 1'b0;
            en     <= 1'b1;
            upd    <= 1'b0;
            err    <= 1'b0;
            brk    <= 1'b0;
        end else begin
            err <= 1'b0;
            upd <= 1'b0;
            case (state)
                BET: if (bus.bet_valid) begin
                    if (accept) begin
                        amount <= bus.bet_amount;
                        side   <= bus.bet_side;
                        state  <= PLAY;
                        en     <= 1'b0;
                    end else begin
                        err <= 1'b1;
                    end
                end
                PLAY: if (bus.round_done) begin
                    pw    <= bus.player_win;
                    dw    <= bus.dealer_win;
                    state <= SETTLE;
                    upd   <= 1'b1;
                end
                SETTLE: begin
                    bal   <= new_balance;
                    state <= new_balance == 8'd0 ? BROKE : BET;
                    en    <= new_balance != 8'd0;
                    brk   <= new_balance == 8'd0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bet_controller.sv
// tb_bet_controller: directed and random bets scored against a behavioural bankroll model.
module tb_bet_controller;
    import bet_controller_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bet_controller_if bus();

    bet_controller #(.INIT_BALANCE(8'd50), .TIE_MULT(8)) dut (
        .slow_clock(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        bit is_settle;
        int val;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int m_bal = 50;
    int m_amt = 0;
    int m_side = 0;
    bit m_play = 0;
    bit m_broke = 0;

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int payout(int b, int a, int s, bit pw, bit dw);
        int v;
        bit tie;
        bit won;
        tie = pw && dw;
        won = (s == 1 && pw && !dw) || (s == 2 && dw && !pw) || (s == 3 && tie);
        if (won) begin
            v = b + (s == 3 ? 8 * a : a);
            return v > 255 ? 255 : v;
        end
        if (tie && (s == 1 || s == 2)) return b;
        return b - a;
    endfunction

    // Monitor: every output pulse must match the head of the expectation queue
    initial begin
        bit pend;
        int exp_bal;
        exp_t e;
        pend = 0;
        exp_bal = 0;
        forever begin
            @(negedge clk);
            if (pend) begin
                check("settled balance", bus.balance, exp_bal);
                pend = 0;
            end
            if (bus.bet_error) begin
                if (q.size() == 0 || q[0].is_settle) check("unexpected bet_error", 1, 0);
                else begin
                    e = q.pop_front();
                    check("bet_error pulse", bus.bet_error, 1);
                end
            end
            if (bus.updatebalanceenable) begin
                if (q.size() == 0 || !q[0].is_settle) check("unexpected settle", 1, 0);
                else begin
                    e = q.pop_front();
                    exp_bal = e.val;
                    pend = 1;
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        bus.bet_valid = 1'b0;
        bus.round_done = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_bal = 50;
        m_play = 0;
        m_broke = 0;
        q.delete();
        check("reset balance", bus.balance, 50);
        check("reset betenabled", bus.betenabled, 1);
        check("reset broke", bus.broke, 0);
        check("reset bet_error", bus.bet_error, 0);
        check("reset updatebalanceenable", bus.updatebalanceenable, 0);
    endtask

    task automatic bet(int a, int s);
        bit ok;
        ok = !m_play && !m_broke && s != 0 && a != 0 && a <= m_bal;
        bus.bet_amount = 8'(a);
        bus.bet_side = 2'(s);
        bus.bet_valid = 1'b1;
        if (!m_play && !m_broke && !ok) q.push_back('{0, 0});
        @(negedge clk);
        bus.bet_valid = 1'b0;
        if (ok) begin
            m_play = 1;
            m_amt = a;
            m_side = s;
        end
        check("betenabled after bet", bus.betenabled, int'(!m_play && !m_broke));
        check("balance after bet", bus.balance, m_bal);
    endtask

    task automatic round(bit pw, bit dw);
        bus.round_done = 1'b1;
        bus.player_win = pw;
        bus.dealer_win = dw;
        if (m_play) begin
            m_bal = payout(m_bal, m_amt, m_side, pw, dw);
            q.push_back('{1, m_bal});
            m_play = 0;
            m_broke = m_bal == 0;
        end
        @(negedge clk);
        bus.round_done = 1'b0;
        bus.player_win = 1'($urandom);
        bus.dealer_win = 1'($urandom);
        repeat (2) @(negedge clk);
        check("broke after round", bus.broke, int'(m_broke));
        check("betenabled after round", bus.betenabled, int'(!m_play && !m_broke));
        check("balance after round", bus.balance, m_bal);
    endtask

    initial begin
        int r;
        int a;
        bus.bet_amount = 8'd0;
        bus.bet_side = 2'b00;
        bus.bet_valid = 1'b0;
        bus.round_done = 1'b0;
        bus.player_win = 1'b0;
        bus.dealer_win = 1'b0;
        @(negedge clk);
        do_reset();
        bet(10, 1);
        round(1, 0);
        do_reset();
        bet(60, 1);
        bet(0, 1);
        bet(10, 0);
        bet(30, 3);
        round(1, 1);
        do_reset();
        bet(20, 2);
        round(1, 1);
        bet(50, 1);
        round(0, 1);
        bet(10, 1);
        round(1, 0);
        do_reset();
        bet(10, 1);
        do_reset();
        round(1, 0);
        bet(5, 2);
        round(0, 0);
        for (int i = 0; i < 400; i++) begin
            if (m_broke) do_reset();
            r = $urandom_range(0, 9);
            if (r < 6) begin
                a = $urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom_range(0, m_bal);
                bet(a, $urandom_range(0, 3));
            end else if (r < 9) begin
                round(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        repeat (3) @(negedge clk);
        check("expectation queue drained", q.size(), 0);
        check("final balance", bus.balance, m_bal);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
